// File: rtl/stream_addr_gen_if.sv
// Output beat bundle of the D2Q9 streaming-address generator.
// A valid/ready handshake carries the per-cell lane addresses, directions and mask.
interface stream_addr_gen_if #(
  parameter int unsigned CW     = 4,
  parameter int unsigned ADDR_W = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_x;
  logic [CW-1:0]         out_y;
  logic [9*ADDR_W-1:0]   out_addr;
  logic [35:0]           out_dir;
  logic [8:0]            out_mask;
  logic                  out_last;

  modport master (
    output out_valid, out_x, out_y, out_addr, out_dir, out_mask, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_addr, out_dir, out_mask, out_last,
    output out_ready
  );
endinterface

// File: rtl/stream_addr_gen.sv
// D2Q9 streaming-address generator: raster-scans an NX x NY grid and emits the nine
// post-streaming destination addresses per cell through a 2-stage stallable pipeline.
module stream_addr_gen #(
  parameter int unsigned NX     = 16,
  parameter int unsigned NY     = 16,
  parameter int unsigned ADDR_W = $clog2(NX * NY),
  parameter int unsigned CW     = $clog2(NX > NY ? NX : NY)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       bnd_mode_i,
  output logic             busy_o,
  output logic             done_o,
  stream_addr_gen_if.master dst
);
  localparam logic [CW-1:0] XMax = CW'(NX - 1);
  localparam logic [CW-1:0] YMax = CW'(NY - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          stall, issue;
  logic [CW-1:0] ix, iy;

  logic          v1_q, s1_last_q;
  logic [CW-1:0] s1_x_q, s1_y_q;
  logic [CW-1:0] s1_xw_q [9];
  logic [CW-1:0] s1_yw_q [9];
  logic [CW-1:0] s1_xw_d [9];
  logic [CW-1:0] s1_yw_d [9];
  logic [8:0]    s1_oob_q, s1_oob_d;

  logic                v2_q, last2_q;
  logic [CW-1:0]       x2_q, y2_q;
  logic [9*ADDR_W-1:0] addr2_q, addr2_d;
  logic [35:0]         dir2_q, dir2_d;
  logic [8:0]          mask2_q, mask2_d;

  function automatic int dx(input int k);
    case (k)
      1, 5, 8: return 1;
      3, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy(input int k);
    case (k)
      2, 5, 6: return 1;
      4, 7, 8: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] opp(input int k);
    case (k)
      1: return 4'd3;
      2: return 4'd4;
      3: return 4'd1;
      4: return 4'd2;
      5: return 4'd7;
      6: return 4'd8;
      7: return 4'd5;
      8: return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  // Row-flipped map: y = NY-1 lands at address 0.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return ADDR_W'((int'(NY) - 1 - int'(y)) * int'(NX) + int'(x));
  endfunction

  assign stall = v2_q & ~dst.out_ready;

  // Cell (0,0) is issued in the accepting cycle so the first beat appears two cycles later.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    ix      = x_q;
    iy      = y_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          issue   = 1'b1;
          ix      = '0;
          iy      = '0;
          x_d     = CW'(1);
          y_d     = '0;
          mode_d  = bnd_mode_i;
          busy_d  = 1'b1;
          state_d = StScan;
        end
      end
      StScan: begin
        if (!stall) begin
          issue = 1'b1;
          if (x_q == XMax) begin
            x_d = '0;
            if (y_q == YMax) state_d = StDrain;
            else y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      StDrain: begin
        if (v2_q && dst.out_ready && last2_q) state_d = StDone;
      end
      StDone: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: wrapped destination coordinates and out-of-range flags per lane.
  always_comb begin
    int xi, yi;
    xi       = 0;
    yi       = 0;
    s1_oob_d = '0;
    s1_xw_d  = '{default: '0};
    s1_yw_d  = '{default: '0};
    for (int k = 0; k < 9; k++) begin
      xi = int'(ix) + dx(k);
      yi = int'(iy) + dy(k);
      s1_oob_d[k] = (xi < 0) || (xi >= int'(NX)) || (yi < 0) || (yi >= int'(NY));
      if (xi < 0)                s1_xw_d[k] = XMax;
      else if (xi >= int'(NX))   s1_xw_d[k] = '0;
      else                       s1_xw_d[k] = CW'(xi);
      if (yi < 0)                s1_yw_d[k] = YMax;
      else if (yi >= int'(NY))   s1_yw_d[k] = '0;
      else                       s1_yw_d[k] = CW'(yi);
    end
  end

  // Stage 2: boundary-mode resolution; mode 3 behaves as open.
  always_comb begin
    addr2_d = '0;
    dir2_d  = '0;
    mask2_d = '0;
    for (int k = 0; k < 9; k++) begin
      addr2_d[(9-k)*ADDR_W-1 -: ADDR_W] = addr_of(s1_xw_q[k], s1_yw_q[k]);
      dir2_d[(9-k)*4-1 -: 4]            = 4'(k);
      mask2_d[k]                        = 1'b1;
      if (s1_oob_q[k]) begin
        if (mode_q == 2'd2) begin
          addr2_d[(9-k)*ADDR_W-1 -: ADDR_W] = addr_of(s1_x_q, s1_y_q);
          dir2_d[(9-k)*4-1 -: 4]            = opp(k);
        end else if (mode_q != 2'd1) begin
          addr2_d[(9-k)*ADDR_W-1 -: ADDR_W] = '1;
          mask2_d[k]                        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      s1_last_q <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_xw_q   <= '{default: '0};
      s1_yw_q   <= '{default: '0};
      s1_oob_q  <= '0;
      v2_q      <= 1'b0;
      last2_q   <= 1'b0;
      x2_q      <= '0;
      y2_q      <= '0;
      addr2_q   <= '0;
      dir2_q    <= '0;
      mask2_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (!stall) begin
        v1_q      <= issue;
        s1_last_q <= (ix == XMax) && (iy == YMax);
        s1_x_q    <= ix;
        s1_y_q    <= iy;
        s1_xw_q   <= s1_xw_d;
        s1_yw_q   <= s1_yw_d;
        s1_oob_q  <= s1_oob_d;
        v2_q      <= v1_q;
        last2_q   <= s1_last_q & v1_q;
        x2_q      <= s1_x_q;
        y2_q      <= s1_y_q;
        addr2_q   <= addr2_d;
        dir2_q    <= dir2_d;
        mask2_q   <= mask2_d;
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign dst.out_valid = v2_q;
  assign dst.out_last  = last2_q;
  assign dst.out_x     = x2_q;
  assign dst.out_y     = y2_q;
  assign dst.out_addr  = addr2_q;
  assign dst.out_dir   = dir2_q;
  assign dst.out_mask  = mask2_q;
endmodule

// File: tb/tb_stream_addr_gen.sv
// Directed bench for stream_addr_gen: a 16x16 instance for modes, stalls and reset,
// plus an 8x4 instance for the small-grid timing.
module tb_stream_addr_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, busy_a, done_a;
  logic [1:0] mode_a;
  logic       rst_b, start_b, busy_b, done_b;
  logic [1:0] mode_b;
  int checks = 0;
  int errors = 0;

  stream_addr_gen_if #(.CW(4), .ADDR_W(8)) ifa ();
  stream_addr_gen_if #(.CW(3), .ADDR_W(5)) ifb ();

  stream_addr_gen dut_a (
    .clk_i(clk), .reset_i(rst_a), .start_i(start_a), .bnd_mode_i(mode_a),
    .busy_o(busy_a), .done_o(done_a), .dst(ifa)
  );

  stream_addr_gen #(.NX(8), .NY(4)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .start_i(start_b), .bnd_mode_i(mode_b),
    .busy_o(busy_b), .done_o(done_b), .dst(ifb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] la(input int k);
    return ifa.out_addr[(9-k)*8-1 -: 8];
  endfunction

  function automatic logic [3:0] lda(input int k);
    return ifa.out_dir[(9-k)*4-1 -: 4];
  endfunction

  function automatic logic [126:0] cur_a();
    return {ifa.out_valid, ifa.out_last, ifa.out_x, ifa.out_y, ifa.out_addr, ifa.out_dir,
            ifa.out_mask};
  endfunction

  function automatic int vx(input int k);
    case (k)
      1, 5, 8: return 1;
      3, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int vy(input int k);
    case (k)
      2, 5, 6: return 1;
      4, 7, 8: return -1;
      default: return 0;
    endcase
  endfunction

  // Open-boundary reference for the 16x16 grid.
  task automatic exp_mode0(input int x, input int y, output logic [71:0] ea,
                           output logic [35:0] ed, output logic [8:0] em);
    int xd, yd;
    ea = '0; ed = '0; em = '0;
    for (int k = 0; k < 9; k++) begin
      xd = x + vx(k);
      yd = y + vy(k);
      ed[(9-k)*4-1 -: 4] = 4'(k);
      if (xd >= 0 && xd < 16 && yd >= 0 && yd < 16) begin
        ea[(9-k)*8-1 -: 8] = 8'((15 - yd) * 16 + xd);
        em[k] = 1'b1;
      end else begin
        ea[(9-k)*8-1 -: 8] = 8'hFF;
      end
    end
  endtask

  task automatic wait_done_a(input string name);
    int cyc;
    cyc = 0;
    while (!done_a && cyc < 600) begin step(); cyc++; end
    checks++;
    if (done_a !== 1'b1) begin
      errors++; $display("FAIL %s done timeout: got %0b want 1", name, done_a);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    step(); step();
    checks++;
    if (cur_a() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h want 0", cur_a());
    end
    checks++;
    if ({busy_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_done: got %b want 00", {busy_a, done_a});
    end
    checks++;
    if ({busy_b, done_b, ifb.out_valid, ifb.out_mask} !== '0) begin
      errors++; $display("FAIL reset_small: got %0h want 0",
                         {busy_b, done_b, ifb.out_valid, ifb.out_mask});
    end
  endtask

  task automatic test_mode0();
    int cyc;
    rst_a = 1'b0; mode_a = 2'd0; step();
    start_a = 1'b1; step(); start_a = 1'b0;
    checks++;
    if ({busy_a, ifa.out_valid} !== 2'b10) begin
      errors++; $display("FAIL m0_cycle1 busy/valid: got %b want 10", {busy_a, ifa.out_valid});
    end
    step();
    checks++;
    if ({ifa.out_valid, ifa.out_x, ifa.out_y} !== 9'h100) begin
      errors++; $display("FAIL m0_first_beat: got %0h want 100",
                         {ifa.out_valid, ifa.out_x, ifa.out_y});
    end
    checks++;
    if ({la(0), la(1), la(2), la(5)} !== {8'd240, 8'd241, 8'd224, 8'd225}) begin
      errors++; $display("FAIL m0_inrange_lanes: got %0h want f0f1e0e1",
                         {la(0), la(1), la(2), la(5)});
    end
    checks++;
    if ({la(3), la(4), la(6), la(7), la(8)} !== {5{8'hFF}}) begin
      errors++; $display("FAIL m0_oob_lanes: got %0h want all ff",
                         {la(3), la(4), la(6), la(7), la(8)});
    end
    checks++;
    if (ifa.out_mask !== 9'b000100111) begin
      errors++; $display("FAIL m0_mask: got %b want 000100111", ifa.out_mask);
    end
    cyc = 2;
    while (!done_a && cyc < 400) begin step(); cyc++; end
    checks++;
    if (cyc !== 259) begin
      errors++; $display("FAIL m0_start_to_done: got %0d want 259", cyc);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++; $display("FAIL m0_busy_at_done: got %0b want 0", busy_a);
    end
  endtask

  task automatic test_mode1();
    mode_a = 2'd1; start_a = 1'b1; step(); start_a = 1'b0; mode_a = 2'd0; step();
    checks++;
    if ({ifa.out_valid, la(3), la(4), la(7)} !== {1'b1, 8'd255, 8'd0, 8'd15}) begin
      errors++; $display("FAIL m1_wrap_lanes: got %0h want 1ff000f",
                         {ifa.out_valid, la(3), la(4), la(7)});
    end
    checks++;
    if (ifa.out_mask !== 9'h1FF) begin
      errors++; $display("FAIL m1_mask: got %h want 1ff", ifa.out_mask);
    end
    wait_done_a("m1");
  endtask

  task automatic test_mode2();
    int cyc;
    mode_a = 2'd2; start_a = 1'b1; step(); start_a = 1'b0; mode_a = 2'd0;
    cyc = 0;
    while (!(ifa.out_valid && ifa.out_x == 4'd15 && ifa.out_y == 4'd15) && cyc < 400) begin
      step(); cyc++;
    end
    checks++;
    if ({la(1), la(2), la(5), la(6), la(8)} !== {5{8'd15}}) begin
      errors++; $display("FAIL m2_bounce_addr: got %0h want all 0f",
                         {la(1), la(2), la(5), la(6), la(8)});
    end
    checks++;
    if ({lda(1), lda(2), lda(5), lda(6), lda(8)} !== 20'h34786) begin
      errors++; $display("FAIL m2_bounce_dir: got %h want 34786",
                         {lda(1), lda(2), lda(5), lda(6), lda(8)});
    end
    checks++;
    if ({la(3), lda(3), la(4), lda(4)} !== {8'd14, 4'd3, 8'd31, 4'd4}) begin
      errors++; $display("FAIL m2_inrange: got %h want 0e31f4", {la(3), lda(3), la(4), lda(4)});
    end
    checks++;
    if ({ifa.out_mask, ifa.out_last} !== {9'h1FF, 1'b1}) begin
      errors++; $display("FAIL m2_mask_last: got %h want 3ff", {ifa.out_mask, ifa.out_last});
    end
    wait_done_a("m2");
  endtask

  task automatic test_full_random();
    int beats, done_cnt, extra, ex, ey;
    logic stalled, pulsed;
    logic [126:0] snap;
    logic [71:0] ea;
    logic [35:0] ed;
    logic [8:0] em;
    beats = 0; done_cnt = 0; extra = 0; ex = 0; ey = 0; stalled = 1'b0; pulsed = 1'b0;
    snap = '0;
    mode_a = 2'd0; start_a = 1'b1; step(); start_a = 1'b0;
    for (int cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
      start_a = 1'b0;
      if (stalled) begin
        checks++;
        if (cur_a() !== snap) begin
          errors++; $display("FAIL rnd_stall_stable: got %h want %h", cur_a(), snap);
        end
      end
      if (done_a) done_cnt++;
      if (beats == 50 && !pulsed) begin
        start_a = 1'b1; mode_a = 2'd2; pulsed = 1'b1;
      end
      ifa.out_ready = 1'($urandom_range(0, 1));
      if (ifa.out_valid && ifa.out_ready) begin
        exp_mode0(ex, ey, ea, ed, em);
        checks++;
        if ({ifa.out_x, ifa.out_y} !== {4'(ex), 4'(ey)}) begin
          errors++; $display("FAIL rnd_order beat %0d: got %h want %h", beats,
                             {ifa.out_x, ifa.out_y}, {4'(ex), 4'(ey)});
        end
        checks++;
        if ({ifa.out_addr, ifa.out_dir, ifa.out_mask} !== {ea, ed, em}) begin
          errors++; $display("FAIL rnd_lanes beat %0d: got %h want %h", beats,
                             {ifa.out_addr, ifa.out_dir, ifa.out_mask}, {ea, ed, em});
        end
        checks++;
        if (ifa.out_last !== (beats == 255)) begin
          errors++; $display("FAIL rnd_last beat %0d: got %0b want %0b", beats,
                             ifa.out_last, beats == 255);
        end
        beats++;
        if (ex == 15) begin ex = 0; ey++; end else ex++;
        stalled = 1'b0;
      end else if (ifa.out_valid) begin
        stalled = 1'b1; snap = cur_a();
      end else begin
        stalled = 1'b0;
      end
      step();
    end
    start_a = 1'b0; mode_a = 2'd0; ifa.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); if (done_a) extra++; end
    checks++;
    if (beats !== 256) begin
      errors++; $display("FAIL rnd_beat_count: got %0d want 256", beats);
    end
    checks++;
    if (done_cnt + extra !== 1) begin
      errors++; $display("FAIL rnd_done_pulses: got %0d want 1", done_cnt + extra);
    end
  endtask

  task automatic test_reset_mid();
    int beats, saw_done;
    beats = 0; saw_done = 0;
    ifa.out_ready = 1'b1; mode_a = 2'd0; start_a = 1'b1; step(); start_a = 1'b0;
    for (int cyc = 0; cyc < 400 && beats < 100; cyc++) begin
      if (ifa.out_valid && ifa.out_ready) beats++;
      if (beats < 100) step();
    end
    rst_a = 1'b1; step();
    checks++;
    if ({busy_a, done_a, cur_a()} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h want 0", {busy_a, done_a, cur_a()});
    end
    rst_a = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (done_a) saw_done++; end
    checks++;
    if (saw_done !== 0) begin
      errors++; $display("FAIL rst_mid_no_done: got %0d want 0", saw_done);
    end
    start_a = 1'b1; step(); start_a = 1'b0; step();
    checks++;
    if ({ifa.out_valid, ifa.out_x, ifa.out_y, la(0)} !== {1'b1, 8'h00, 8'd240}) begin
      errors++; $display("FAIL rst_mid_restart: got %h want 100f0",
                         {ifa.out_valid, ifa.out_x, ifa.out_y, la(0)});
    end
    wait_done_a("restart");
  endtask

  task automatic test_small_grid();
    int cyc, beats;
    logic seen_corner;
    cyc = 0; beats = 0; seen_corner = 1'b0;
    rst_b = 1'b0; mode_b = 2'd0; step();
    start_b = 1'b1; step(); start_b = 1'b0; cyc = 1;
    while (!done_b && cyc < 200) begin
      if (ifb.out_valid && ifb.out_ready) begin
        beats++;
        if (ifb.out_x == 3'd7 && ifb.out_y == 3'd3) begin
          seen_corner = 1'b1;
          checks++;
          if ({ifb.out_addr[44:40], ifb.out_mask[1], ifb.out_last} !== {5'd7, 1'b0, 1'b1}) begin
            errors++; $display("FAIL small_corner: got %h want 1d",
                               {ifb.out_addr[44:40], ifb.out_mask[1], ifb.out_last});
          end
        end
      end
      step(); cyc++;
    end
    checks++;
    if (cyc !== 35) begin
      errors++; $display("FAIL small_start_to_done: got %0d want 35", cyc);
    end
    checks++;
    if ({beats, seen_corner} !== {32'd32, 1'b1}) begin
      errors++; $display("FAIL small_beats: got %0d/%0b want 32/1", beats, seen_corner);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_mode2();
    test_full_random();
    test_reset_mid();
    test_small_grid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
